// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioner.
//   BTN_DEF_NUM_BTN         - default channel count
//   BTN_DEF_DEBOUNCE_CYCLES - default stability window (10 ms at 50 MHz)
//   BTN_REL_LEVEL_AL/_AH    - pin level of a released button for
//                             active-low / active-high boards
package btn_pkg;

  localparam int   BTN_DEF_NUM_BTN         = 3;
  localparam int   BTN_DEF_DEBOUNCE_CYCLES = 500000;

  localparam logic BTN_REL_LEVEL_AL = 1'b1;
  localparam logic BTN_REL_LEVEL_AH = 1'b0;

  // Pin level seen while the button is not pressed.
  function automatic logic btn_rel_level(input bit active_low);
    return active_low ? BTN_REL_LEVEL_AL : BTN_REL_LEVEL_AH;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One push-button channel: 2-flop synchronizer, polarity fix-up,
// stability counter and debounced level flop.
// Optional feature macro: BTN_PRESS_PULSE_EN adds a one-cycle press pulse.
// Ports:
//   clk         - rising-edge clock
//   reset_n     - asynchronous active-low reset
//   raw         - asynchronous raw pin
//   press_pulse - (BTN_PRESS_PULSE_EN only) 1-cycle pulse after level rises
//   level       - debounced level, 1 = pressed, straight from a flop
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEF_DEBOUNCE_CYCLES,  // >= 1
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
`ifdef BTN_PRESS_PULSE_EN
  output logic press_pulse,
`endif
  output logic level
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           REL      = btn_rel_level(ACTIVE_LOW);

  logic [1:0]    sync_ff;
  logic          sync;
  logic [CW-1:0] cnt;

  // Synchronizer resets to the released pin level so that releasing
  // reset with buttons up does not look like a disagreement.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_ff <= {2{REL}};
    else          sync_ff <= {sync_ff[0], raw};

  assign sync = ACTIVE_LOW ? ~sync_ff[1] : sync_ff[1];

  // Counter tracks consecutive disagreement; any agreeing cycle restarts
  // it, and the level only follows after DEBOUNCE_CYCLES of disagreement.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync == level) begin
      cnt   <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync;
    end else begin
      cnt   <= cnt + CW'(1);
    end

`ifdef BTN_PRESS_PULSE_EN
  logic level_d;

  // Pulse lands on the edge after level rises; releases produce nothing.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      level_d     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      level_d     <= level;
      press_pulse <= level & ~level_d;
    end
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BTN asynchronous push-button pins into clean levels
// (feeds the button input PIO).
// Optional feature macro: BTN_PRESS_PULSE_EN adds port press_pulse.
// Ports:
//   clk         - rising-edge clock
//   reset_n     - asynchronous active-low reset
//   btn_raw     - raw button pins, NUM_BTN bits
//   press_pulse - (BTN_PRESS_PULSE_EN only) 1-cycle press pulses
//   btn_level   - debounced levels, 1 = pressed
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = BTN_DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = BTN_DEF_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
`ifdef BTN_PRESS_PULSE_EN
  output logic [NUM_BTN-1:0] press_pulse,
`endif
  output logic [NUM_BTN-1:0] btn_level
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW != 0)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .raw         (btn_raw[i]),
`ifdef BTN_PRESS_PULSE_EN
      .press_pulse (press_pulse[i]),
`endif
      .level       (btn_level[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1, NUM_BTN=3). Directed scenarios check exact edge timing;
// a random phase compares against a window-based reference model:
// the level flips when the last D synchronized samples all disagree.
module tb_button_conditioner;

  localparam int N = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] btn_level;
`ifdef BTN_PRESS_PULSE_EN
  logic [N-1:0] press_pulse;
`endif

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .NUM_BTN         (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
`ifdef BTN_PRESS_PULSE_EN
    .press_pulse (press_pulse),
`endif
    .btn_level   (btn_level)
  );

  always #5 clk = ~clk;

  // Reference model. hist[0] = pressed value sampled at the previous edge;
  // a sample taken at edge k reaches the sync output before edge k+2, so
  // at edge t the synchronized window is hist[1..D].
  logic [D:0][N-1:0] hist;
  logic [N-1:0]      m_level;
`ifdef BTN_PRESS_PULSE_EN
  logic [N-1:0]      m_rose;
  logic [N-1:0]      m_pulse;
`endif

  function automatic logic window_disagrees(int ch);
    for (int k = 1; k <= D; k++)
      if (hist[k][ch] == m_level[ch]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist    <= '0;
      m_level <= '0;
`ifdef BTN_PRESS_PULSE_EN
      m_rose  <= '0;
      m_pulse <= '0;
`endif
    end else begin
      for (int i = 0; i < N; i++) begin
        if (window_disagrees(i)) m_level[i] <= ~m_level[i];
`ifdef BTN_PRESS_PULSE_EN
        m_rose[i] <= window_disagrees(i) & ~m_level[i];
`endif
      end
`ifdef BTN_PRESS_PULSE_EN
      m_pulse <= m_rose;
`endif
      hist <= {hist[D-1:0], ~btn_raw};
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    btn_raw = 3'b111;
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: btn_level=%b expected 000", c, btn_level);
      end
    end
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== 3'b000) begin
        errors++;
        $display("FAIL reset_after cycle %0d: btn_level=%b expected 000", c, btn_level);
      end
`ifdef BTN_PRESS_PULSE_EN
      checks++;
      if (press_pulse !== 3'b000) begin
        errors++;
        $display("FAIL reset_pulse cycle %0d: press_pulse=%b expected 000", c, press_pulse);
      end
`endif
    end
  endtask

  task automatic test_clean_press();
    logic [N-1:0] exp_l;
    @(negedge clk);
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      exp_l = (e >= 6) ? 3'b001 : 3'b000;
      checks++;
      if (btn_level !== exp_l) begin
        errors++;
        $display("FAIL clean_press edge %0d: btn_level=%b expected %b", e, btn_level, exp_l);
      end
`ifdef BTN_PRESS_PULSE_EN
      checks++;
      if (press_pulse !== ((e == 7) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL clean_pulse edge %0d: press_pulse=%b", e, press_pulse);
      end
`endif
    end
    btn_raw[0] = 1'b1;
    idle(10);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    btn_raw[1] = 1'b0;
    idle(3);
    btn_raw[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== 3'b000) begin
        errors++;
        $display("FAIL glitch cycle %0d: btn_level=%b expected 000", c, btn_level);
      end
    end
    // A fresh press must need the full window again, proving the restart.
    btn_raw[1] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== ((e >= 6) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("FAIL glitch_repress edge %0d: btn_level=%b", e, btn_level);
      end
    end
    btn_raw[1] = 1'b1;
    idle(10);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    btn_raw = 3'b000;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== ((e >= 6) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL simultaneous edge %0d: btn_level=%b", e, btn_level);
      end
`ifdef BTN_PRESS_PULSE_EN
      checks++;
      if (press_pulse !== ((e == 7) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL simul_pulse edge %0d: press_pulse=%b", e, press_pulse);
      end
`endif
    end
  endtask

  task automatic test_release();
    // Entered with all three held and debounced as pressed.
    btn_raw[2] = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== ((e >= 6) ? 3'b011 : 3'b111)) begin
        errors++;
        $display("FAIL release edge %0d: btn_level=%b", e, btn_level);
      end
`ifdef BTN_PRESS_PULSE_EN
      checks++;
      if (press_pulse !== 3'b000) begin
        errors++;
        $display("FAIL release_pulse edge %0d: press_pulse=%b expected 000", e, press_pulse);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_count();
    btn_raw = 3'b111;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(4);
    btn_raw = 3'b110;
    idle(4);
    reset_n = 1'b0;
    #1;
    checks++;
    if (btn_level !== 3'b000) begin
      errors++;
      $display("FAIL midreset_assert: btn_level=%b expected 000", btn_level);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== ((e >= 6) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL midreset_release edge %0d: btn_level=%b", e, btn_level);
      end
    end
    btn_raw = 3'b111;
    idle(10);
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== m_level) begin
        errors++;
        $display("FAIL random cycle %0d: btn_level=%b expected %b", c, btn_level, m_level);
      end
`ifdef BTN_PRESS_PULSE_EN
      checks++;
      if (press_pulse !== m_pulse) begin
        errors++;
        $display("FAIL random_pulse cycle %0d: press_pulse=%b expected %b", c, press_pulse, m_pulse);
      end
`endif
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) btn_raw[i] = ~btn_raw[i];
      reset_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_release();
    test_reset_mid_count();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
